// File: rtl/draw_scheduler.sv
// draw_scheduler: queues sprite draw requests, steps the datapath pixel counter and runs a full-screen clear sweep.
// Latency: first drw_en 2 cycles after a request lands in an idle queue; plot follows drw_en by 1 cycle.
// Backpressure: req_ready drops when the queue is full, a clear is pending, or the clear sweep is running.
// Optional: define DRAW_SCHED_STATS_EN to add the pix_total sprite-plot counter output.
module draw_scheduler #(
  parameter int         FIFO_DEPTH = 4,
  parameter int         SCREEN_W   = 128,
  parameter int         SCREEN_H   = 120,
  parameter logic [2:0] BG_COLOUR  = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [4:0] req_img,
  input  logic [6:0] req_x,
  input  logic [6:0] req_y,
  input  logic [2:0] req_colour,
  input  logic       clear_req,
  output logic       drw_en,
  output logic [4:0] drw_img,
  output logic [6:0] drw_sx,
  output logic [6:0] drw_sy,
  output logic [3:0] drw_counter,
  input  logic [6:0] dp_x,
  input  logic [6:0] dp_y,
  output logic [6:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       sprite_done,
  output logic       busy
`ifdef DRAW_SCHED_STATS_EN
  ,
  output logic [15:0] pix_total
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, DRAW, FLUSH, CLEAR} state_t;

  typedef struct packed {
    logic [4:0] img;
    logic [6:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } req_t;

  // Pixels per sprite; ids outside the table draw nothing.
  function automatic logic [3:0] pix_count(input logic [4:0] img);
    case (img)
      5'd1:    pix_count = 4'd9;
      5'd2:    pix_count = 4'd5;
      5'd3:    pix_count = 4'd9;
      5'd4:    pix_count = 4'd7;
      5'd5:    pix_count = 4'd7;
      5'd6:    pix_count = 4'd12;
      5'd7:    pix_count = 4'd13;
      5'd8:    pix_count = 4'd8;
      5'd9:    pix_count = 4'd11;
      5'd10:   pix_count = 4'd13;
      default: pix_count = 4'd0;
    endcase
  endfunction

  state_t        state_q, state_d;
  req_t          fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   fifo_cnt_q;
  req_t          work_q, work_d;
  logic [3:0]    k_q, k_d;
  logic [3:0]    last_q, last_d;
  logic [6:0]    cx_q, cx_d;
  logic [6:0]    cy_q, cy_d;
  logic          clear_pending_q, clear_pending_d;
  logic          pix_sel_q;
  logic [2:0]    pix_col_q;
  logic          sprite_done_q, done_d;

  logic          fifo_empty, fifo_full;
  logic          push, pop, flush;
  req_t          head;
  logic [3:0]    head_count;
  logic          in_clear;

  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == (AW+1)'(FIFO_DEPTH));
  assign head       = fifo_mem_q[rd_ptr_q];
  assign head_count = pix_count(head.img);
  assign in_clear   = (state_q == CLEAR);
  assign pop        = (state_q == LOAD);
  // A full queue may still take a request on the cycle its head is popped.
  assign req_ready  = (!fifo_full || pop) && !clear_pending_q && !in_clear;
  assign push       = req_valid && req_ready;

  // Next-state, working-register and sweep-counter logic.
  always_comb begin
    state_d         = state_q;
    work_d          = work_q;
    k_d             = k_q;
    last_d          = last_q;
    cx_d            = cx_q;
    cy_d            = cy_q;
    clear_pending_d = clear_pending_q;
    flush           = 1'b0;
    done_d          = 1'b0;
    if (clear_req && !in_clear) clear_pending_d = 1'b1;
    case (state_q)
      IDLE: begin
        // Clear outranks queued sprites; queue contents are dropped on entry.
        if (clear_pending_q || clear_req) begin
          state_d = CLEAR;
          flush   = 1'b1;
          cx_d    = '0;
          cy_d    = '0;
        end else if (!fifo_empty) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        work_d = head;
        k_d    = '0;
        last_d = head_count - 4'd1;
        if (head_count == 4'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = DRAW;
        end
      end
      DRAW: begin
        if (k_q == last_q) state_d = FLUSH;
        else               k_d     = k_q + 4'd1;
      end
      FLUSH: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      CLEAR: begin
        if (cx_q == 7'(SCREEN_W - 1)) begin
          cx_d = '0;
          if (cy_q == 7'(SCREEN_H - 1)) begin
            cy_d            = '0;
            clear_pending_d = 1'b0;
            state_d         = IDLE;
          end else begin
            cy_d = cy_q + 7'd1;
          end
        end else begin
          cx_d = cx_q + 7'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, working registers and plot-alignment pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      work_q          <= '0;
      k_q             <= '0;
      last_q          <= '0;
      cx_q            <= '0;
      cy_q            <= '0;
      clear_pending_q <= 1'b0;
      pix_sel_q       <= 1'b0;
      pix_col_q       <= '0;
      sprite_done_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      work_q          <= work_d;
      k_q             <= k_d;
      last_q          <= last_d;
      cx_q            <= cx_d;
      cy_q            <= cy_d;
      clear_pending_q <= clear_pending_d;
      pix_sel_q       <= drw_en;
      pix_col_q       <= drw_en ? work_q.colour : 3'b000;
      sprite_done_q   <= done_d;
    end
  end

  // Request queue; a flush wins over a simultaneous push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else if (flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= '{img: req_img, x: req_x, y: req_y, colour: req_colour};
        wr_ptr_q             <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      fifo_cnt_q <= fifo_cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign drw_en      = (state_q == DRAW);
  assign drw_img     = work_q.img;
  assign drw_sx      = work_q.x;
  assign drw_sy      = work_q.y;
  assign drw_counter = drw_en ? k_q : 4'd0;
  assign plot        = pix_sel_q || in_clear;
  assign vga_x       = pix_sel_q ? dp_x : (in_clear ? cx_q : 7'd0);
  assign vga_y       = pix_sel_q ? dp_y : (in_clear ? cy_q : 7'd0);
  assign vga_colour  = pix_sel_q ? pix_col_q : (in_clear ? BG_COLOUR : 3'b000);
  assign sprite_done = sprite_done_q;
  assign busy        = !((state_q == IDLE) && fifo_empty);

`ifdef DRAW_SCHED_STATS_EN
  logic [15:0] pix_total_q;

  // Saturating count of sprite plot cycles, zeroed when a clear begins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  pix_total_q <= '0;
    else if (flush)                             pix_total_q <= '0;
    else if (pix_sel_q && pix_total_q != 16'hFFFF) pix_total_q <= pix_total_q + 16'd1;
  end

  assign pix_total = pix_total_q;
`endif

endmodule

// File: tb/tb_draw_scheduler.sv
// Testbench for draw_scheduler: directed requests, a stub datapath and a plot-event scoreboard.
// Latency: checks every plot cycle against the expected event stream.
// Backpressure: requests are held until req_ready, with a bounded wait.
module tb_draw_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [4:0] req_img = '0;
  logic [6:0] req_x = '0;
  logic [6:0] req_y = '0;
  logic [2:0] req_colour = '0;
  logic       clear_req = 1'b0;
  logic       drw_en;
  logic [4:0] drw_img;
  logic [6:0] drw_sx, drw_sy;
  logic [3:0] drw_counter;
  logic [6:0] dp_x = '0, dp_y = '0;
  logic [6:0] vga_x, vga_y;
  logic [2:0] vga_colour;
  logic       plot, sprite_done, busy;
`ifdef DRAW_SCHED_STATS_EN
  logic [15:0] pix_total;
`endif

  always #5 clk = ~clk;

  draw_scheduler dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_img(req_img), .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
    .clear_req(clear_req),
    .drw_en(drw_en), .drw_img(drw_img), .drw_sx(drw_sx), .drw_sy(drw_sy),
    .drw_counter(drw_counter),
    .dp_x(dp_x), .dp_y(dp_y),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .plot(plot), .sprite_done(sprite_done), .busy(busy)
`ifdef DRAW_SCHED_STATS_EN
    , .pix_total(pix_total)
`endif
  );

  // Stub datapath: pixel k of a sprite lands at (sx+k, sy+img), one cycle later.
  always @(posedge clk) begin
    dp_x <= drw_sx + {3'b000, drw_counter};
    dp_y <= drw_sy + {2'b00, drw_img};
  end

  typedef struct packed {
    logic [6:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        exp_e;
  int         chk_cnt = 0;
  int         pass_cnt = 0;
  int         plot_cnt = 0;
  int         done_cnt = 0;
  logic [6:0] last_x = '0, last_y = '0;

  function automatic int lut(input logic [4:0] img);
    case (img)
      5'd1: return 9;   5'd2: return 5;   5'd3: return 9;   5'd4: return 7;
      5'd5: return 7;   5'd6: return 12;  5'd7: return 13;  5'd8: return 8;
      5'd9: return 11;  5'd10: return 13;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_timeout(input string name);
    chk_cnt++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Scoreboard: every plot cycle must match the next expected event.
  always @(negedge clk) begin
    if (!reset && plot === 1'b1) begin
      plot_cnt++;
      last_x = vga_x;
      last_y = vga_y;
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_plot: got plot at (%0d,%0d) expected none", vga_x, vga_y);
      end else begin
        exp_e = exp_q.pop_front();
        check("plot_pix", 32'({vga_x, vga_y, vga_colour}), 32'(exp_e));
      end
    end
    if (!reset && sprite_done === 1'b1) done_cnt++;
  end

  // Offer a request until taken; n_exp<0 means all of the sprite's pixels are expected.
  task automatic push(input logic [4:0] img, input logic [6:0] x, input logic [6:0] y,
                      input logic [2:0] c, input int n_exp);
    int n;
    bit ok;
    ok = 1'b0;
    req_valid = 1'b1; req_img = img; req_x = x; req_y = y; req_colour = c;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) fail_timeout("push_accept");
    else begin
      n = (n_exp < 0) ? lut(img) : n_exp;
      for (int k = 0; k < n; k++) exp_q.push_back({7'(x + 7'(k)), 7'(y + {2'b00, img}), c});
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic clear_pulse();
    for (int yy = 0; yy < 120; yy++)
      for (int xx = 0; xx < 128; xx++) exp_q.push_back({7'(xx), 7'(yy), 3'b000});
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
  endtask

  task automatic wait_drw(input logic [3:0] k);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (drw_en === 1'b1 && drw_counter === k) begin ok = 1'b1; break; end
    end
    if (!ok) fail_timeout("wait_drw_en");
  endtask

  task automatic wait_drain(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin fail_timeout(name); exp_q.delete(); end
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, p0;
    // Reset state
    @(negedge clk);
    check("rst_plot", 32'(plot), 32'd0);
    check("rst_drw_en", 32'(drw_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(sprite_done), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_vga", 32'({vga_x, vga_y, vga_colour}), 32'd0);
    check("rst_drw", 32'({drw_img, drw_sx, drw_sy, drw_counter}), 32'd0);
    @(posedge clk); #3; reset = 1'b0;
    @(posedge clk); #1;

    // Single head sprite: counter walk, plot alignment, done pulse
    d0 = done_cnt;
    push(5'd1, 7'd40, 7'd20, 3'b100, -1);
    wait_drw(4'd0);
    check("t1_sx", 32'(drw_sx), 32'd40);
    check("t1_img", 32'(drw_img), 32'd1);
    for (int k = 0; k < 9; k++) begin
      check("t1_drw_en", 32'(drw_en), 32'd1);
      check("t1_counter", 32'(drw_counter), 32'(k));
      check("t1_plot_lag", 32'(plot), (k == 0) ? 32'd0 : 32'd1);
      if (k == 1) check("t1_first_pix", 32'({vga_x, vga_y, vga_colour}), 32'({7'd40, 7'd21, 3'b100}));
      @(negedge clk);
    end
    check("t1_flush_drw_en", 32'(drw_en), 32'd0);
    check("t1_flush_plot", 32'(plot), 32'd1);
    check("t1_flush_done", 32'(sprite_done), 32'd0);
    @(negedge clk);
    check("t1_done_plot", 32'(plot), 32'd0);
    check("t1_done_pulse", 32'(sprite_done), 32'd1);
    @(negedge clk);
    check("t1_done_once", 32'(sprite_done), 32'd0);
    check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
    @(posedge clk); #1;

    // Queue fill while drawing: backpressure at full, order and plot total
    d0 = done_cnt; p0 = plot_cnt;
    push(5'd7, 7'd5, 7'd5, 3'b001, -1);
    wait_drw(4'd0);
    @(posedge clk); #1;
    push(5'd1, 7'd20, 7'd40, 3'b010, -1);
    push(5'd3, 7'd30, 7'd40, 3'b011, -1);
    push(5'd10, 7'd40, 7'd40, 3'b101, -1);
    push(5'd6, 7'd50, 7'd40, 3'b110, -1);
    @(negedge clk);
    check("t2_ready_full", 32'(req_ready), 32'd0);
    check("t2_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    push(5'd9, 7'd60, 7'd60, 3'b111, -1);
    wait_drain("t2_drain", 500);
    repeat (4) @(negedge clk);
    check("t2_plot_total", 32'(plot_cnt - p0), 32'd67);
    check("t2_done_total", 32'(done_cnt - d0), 32'd6);
    check("t2_idle_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Zero-pixel letter followed by body
    d0 = done_cnt; p0 = plot_cnt;
    push(5'd20, 7'd10, 7'd10, 3'b001, -1);
    push(5'd2, 7'd10, 7'd10, 3'b011, -1);
    wait_drain("t3_drain", 200);
    repeat (4) @(negedge clk);
    check("t3_plot_total", 32'(plot_cnt - p0), 32'd5);
    check("t3_done_total", 32'(done_cnt - d0), 32'd2);
    @(posedge clk); #1;

    // Clear mid-sprite with two queued entries
    d0 = done_cnt; p0 = plot_cnt;
    push(5'd7, 7'd10, 7'd30, 3'b010, -1);
    wait_drw(4'd0);
    @(posedge clk); #1;
    push(5'd1, 7'd0, 7'd0, 3'b001, 0);
    push(5'd2, 7'd0, 7'd0, 3'b001, 0);
    clear_pulse();
    repeat (200) @(negedge clk);
    check("t4_ready_in_clear", 32'(req_ready), 32'd0);
    check("t4_busy_in_clear", 32'(busy), 32'd1);
    check("t4_plot_in_clear", 32'(plot), 32'd1);
    @(posedge clk); #1;
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    wait_drain("t4_drain", 16000);
    check("t4_last_xy", 32'({last_x, last_y}), 32'({7'd127, 7'd119}));
    @(negedge clk);
    check("t4_busy_after", 32'(busy), 32'd0);
    check("t4_plot_after", 32'(plot), 32'd0);
    repeat (10) @(negedge clk);
    check("t4_plot_total", 32'(plot_cnt - p0), 32'd15373);
    check("t4_done_total", 32'(done_cnt - d0), 32'd1);
    @(posedge clk); #1;

    // Reset while drawing pixel 4
    d0 = done_cnt;
    push(5'd7, 7'd50, 7'd50, 3'b001, 4);
    wait_drw(4'd4);
    #2; reset = 1'b1;
    #1;
    check("t5_plot", 32'(plot), 32'd0);
    check("t5_drw_en", 32'(drw_en), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #3; reset = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_busy_after", 32'(busy), 32'd0);
    check("t5_drw_en_after", 32'(drw_en), 32'd0);
    check("t5_no_pending", 32'(exp_q.size()), 32'd0);
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    @(posedge clk); #1;

`ifdef DRAW_SCHED_STATS_EN
    check("st_reset", 32'(pix_total), 32'd0);
    push(5'd1, 7'd3, 7'd3, 3'b001, -1);
    push(5'd3, 7'd3, 7'd3, 3'b010, -1);
    wait_drain("st_drain", 300);
    repeat (3) @(negedge clk);
    check("st_total", 32'(pix_total), 32'd18);
    @(posedge clk); #1;
    clear_pulse();
    repeat (3) @(negedge clk);
    check("st_cleared", 32'(pix_total), 32'd0);
    wait_drain("st_clear_drain", 16000);
    @(negedge clk);
    check("st_clear_not_counted", 32'(pix_total), 32'd0);
    @(posedge clk); #1;
`endif

    // Queue is empty after reset: a fresh sprite draws alone
    d0 = done_cnt; p0 = plot_cnt;
    push(5'd2, 7'd1, 7'd1, 3'b110, -1);
    wait_drain("t6_drain", 200);
    repeat (4) @(negedge clk);
    check("t6_plot_total", 32'(plot_cnt - p0), 32'd5);
    check("t6_done_total", 32'(done_cnt - d0), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/draw_scheduler.md
Name: draw_scheduler

Overview:
- Sequences the hangman sprite/letter draw datapath: queues draw requests (sprite id, anchor, colour) and steps the datapath's 4-bit pixel counter through each sprite.
- Aligns the datapath's registered pixel output with a VGA plot strobe and muxes in a full-screen clear sweep.
- Sits between the game FSM (requesters) and the draw datapath / VGA adapter.

Parameters:
- FIFO_DEPTH, 4, request queue entries (power of two, 2..16)
- SCREEN_W, 128, clear sweep width in pixels (x 0..SCREEN_W-1)
- SCREEN_H, 120, clear sweep height in pixels (y 0..SCREEN_H-1)
- BG_COLOUR, 3'b000, colour plotted during clear

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req_valid  in  1  draw request offered
- req_ready  out  1  request accepted when req_valid&req_ready at clk edge
- req_img  in  5  sprite id (1 head, 2 body, 3 arms, 4 left leg, 5 right leg, 6..31 letters A..Z)
- req_x  in  7  sprite anchor x
- req_y  in  7  sprite anchor y
- req_colour  in  3  sprite colour
- clear_req  in  1  single-cycle pulse: request screen clear
- drw_en  out  1  datapath enable
- drw_img  out  5  datapath sprite id
- drw_sx  out  7  datapath anchor x
- drw_sy  out  7  datapath anchor y
- drw_counter  out  4  datapath pixel index
- dp_x  in  7  datapath pixel x (valid 1 cycle after drw_counter)
- dp_y  in  7  datapath pixel y
- vga_x  out  7  plot x
- vga_y  out  7  plot y
- vga_colour  out  3  plot colour
- plot  out  1  VGA write strobe
- sprite_done  out  1  1-cycle pulse after a sprite's last pixel is plotted
- busy  out  1  high in any state except IDLE with empty FIFO

Behaviour:
- Reset (async): state IDLE, FIFO empty, clear_pending=0; all outputs 0 except req_ready=1.
- FIFO: FIFO_DEPTH entries of {img, x, y, colour}. req_ready = !full && !clear_pending && state!=CLEAR. A push in the same cycle as a pop is allowed when full.
- Pixel count LUT by img: 1:9, 2:5, 3:9, 4:7, 5:7, 6:12, 7:13, 8:8, 9:11, 10:13; all others 0. A count of 0 pops the entry, pulses sprite_done, and emits no drw_en and no plot.
- States:
  - IDLE: if clear_pending, go to CLEAR; else if FIFO non-empty, go to LOAD.
  - LOAD (1 cycle): pop head into working registers; k=0.
  - DRAW: drw_en=1, drw_counter=k, drw_img/sx/sy from working registers; k increments each cycle. At k=count-1, go to FLUSH.
  - FLUSH (1 cycle): drw_en=0; the last pixel plots; sprite_done pulses in the following cycle; go to IDLE.
  - CLEAR: raster sweep with y outer, x inner, from (0,0) to (SCREEN_W-1, SCREEN_H-1). One pixel per cycle: plot=1, vga_x/vga_y = sweep counters, vga_colour=BG_COLOUR. After the last pixel, clear_pending=0, then IDLE.
- Plot alignment: plot, vga_colour and the "pixel from datapath" select are drw_en/colour delayed 1 cycle. When that select is set, vga_x=dp_x and vga_y=dp_y. A sprite of N pixels produces exactly N consecutive plot cycles, first plot one cycle after first drw_en.
- clear_req: sets clear_pending in any state.
  - In DRAW/FLUSH, the current sprite completes, then the FIFO is flushed (entries discarded, no sprite_done), then CLEAR runs.
  - In IDLE, CLEAR starts the next cycle. The FIFO is flushed on entry to CLEAR.
  - clear_req during CLEAR is ignored (no restart).
- A request offered on the same edge as clear_req is accepted only if req_ready was 1 at that edge. It is then discarded by the flush.
- Coordinate arithmetic is the datapath's; no wrap checks in this block.
- Reset mid-DRAW/CLEAR: immediate abort, plot=0 asynchronously.

Optional Feature:
- Macro: DRAW_SCHED_STATS_EN.
- When defined: adds output pix_total [15:0], counting plot cycles from sprites only (not clear). It saturates at 16'hFFFF and is cleared by reset or entry to CLEAR.
- When undefined: no port and no counter logic.

Test Plan:
- Push img=1 at (40,20), colour 3'b100 → drw_counter 0..8 on 9 consecutive cycles; plot high 9 cycles starting 1 cycle after drw_en; vga_x/vga_y track dp_x/dp_y; sprite_done single pulse after last plot.
- Push 5 requests back-to-back (FIFO_DEPTH=4) while the first draws → req_ready drops at full; all accepted sprites are drawn in order; total plot count equals the sum of the LUT counts.
- Push img=20 (count 0) then img=2 → no plot for img 20, sprite_done pulses once for it, then 5 plots for body.
- clear_req mid-sprite img=7 with 2 queued → img 7 finishes its 13 plots; queued entries are not drawn; 15360 plot cycles follow with colour 000, last at (127,119); busy falls after.
- Assert reset during DRAW at k=4 → plot, drw_en and busy go to 0 immediately; req_ready=1; FIFO empty on release.
- With DRAW_SCHED_STATS_EN: draw img 1 then img 3 → pix_total=18; clear_req → pix_total=0.
